// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider with a start/done handshake.
//
// Takes an n-bit dividend and an m-bit divisor. Per operation, k selects
// two's-complement signed (k=1) or unsigned (k=0) interpretation. Produces
// an n-bit quotient and an m-bit remainder that satisfy q*b + r == a, with
// truncating signed semantics (the same as Verilog / and %).
//
// Latency is n+1 cycles from the accepted start to done. Divide-by-zero
// takes 1 cycle.
//
// Optional feature: define DIV_OVF_FLAG_EN to add the ovf output. It flags
// the signed most-negative / -1 case. The wrapped quotient is produced
// either way.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset; aborts any operation
//   start  in   request, sampled only while idle
//   a      in   [n-1:0] dividend, sampled with start
//   b      in   [m-1:0] divisor, sampled with start
//   k      in   1 = signed, 0 = unsigned, sampled with start
//   busy   out  operation in progress
//   done   out  one-cycle pulse; q/r/dz (and ovf) valid from this cycle
//   q      out  [n-1:0] quotient, held until the next result
//   r      out  [m-1:0] remainder, held until the next result
//   dz     out  divide-by-zero flag for the last operation
//   ovf    out  (DIV_OVF_FLAG_EN only) signed most-negative / -1 flag

module seq_divider #(
  parameter int unsigned n = 8,
  parameter int unsigned m = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [m-1:0] b,
  input  logic         k,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] q,
  output logic [m-1:0] r,
  output logic         dz
`ifdef DIV_OVF_FLAG_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned CntW = $clog2(n + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e state_q, state_d;

  // Datapath state. The quotient shift register starts out holding the
  // dividend magnitude. Each step shifts out its MSB into the partial
  // remainder and shifts the new quotient bit in at the LSB.
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [m-1:0]    rem_q, rem_d;
  logic [n-1:0]    quo_q, quo_d;
  logic [m-1:0]    dvs_q, dvs_d;
  logic            a_neg_q, a_neg_d;     // remainder takes dividend sign
  logic            q_neg_q, q_neg_d;     // operand signs differ
  logic            dz_pend_q, dz_pend_d; // current op is a divide-by-zero

  // Output registers.
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [n-1:0] q_q, q_d;
  logic [m-1:0] r_q, r_d;
  logic         dz_q, dz_d;

`ifdef DIV_OVF_FLAG_EN
  logic ovf_pend_q, ovf_pend_d;
  logic ovf_q, ovf_d;
  logic ovf_in;
`endif

  // Operand decode at the input.
  logic         a_neg_in;
  logic         b_neg_in;
  logic [n-1:0] a_mag;
  logic [m-1:0] b_mag;
  logic         b_zero;

  assign a_neg_in = k & a[n-1];
  assign b_neg_in = k & b[m-1];
  // The most negative value negates to itself. Read back as unsigned, that
  // is 2^(n-1) (or 2^(m-1)), which is exactly the magnitude needed.
  assign a_mag    = a_neg_in ? (~a + {{(n-1){1'b0}}, 1'b1}) : a;
  assign b_mag    = b_neg_in ? (~b + {{(m-1){1'b0}}, 1'b1}) : b;
  assign b_zero   = (b == '0);

`ifdef DIV_OVF_FLAG_EN
  assign ovf_in = k & (a == {1'b1, {(n-1){1'b0}}}) & (b == '1);
`endif

  // One restoring step.
  // The shifted value is (m+1) bits. After a successful subtract it is
  // always below 2*dvs. So when the subtract is non-negative, the result
  // fits in m bits. When it is negative, the wrapped value always has
  // bit m set. Bit m of the difference therefore works as the sign test.
  logic [m:0]   shifted;
  logic [m:0]   trial;
  logic         q_bit;
  logic [m-1:0] rem_step;
  logic [n-1:0] quo_step;

  assign shifted  = {rem_q, quo_q[n-1]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign q_bit    = ~trial[m];
  assign rem_step = q_bit ? trial[m-1:0] : shifted[m-1:0];
  assign quo_step = {quo_q[n-2:0], q_bit};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = b_zero ? StFix : StCalc;
        end
      end
      StCalc: begin
        // The last step runs while the counter still reads 1.
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output next-values.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    a_neg_d   = a_neg_q;
    q_neg_d   = q_neg_q;
    dz_pend_d = dz_pend_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;
`ifdef DIV_OVF_FLAG_EN
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          busy_d    = 1'b1;
          a_neg_d   = a_neg_in;
          q_neg_d   = a_neg_in ^ b_neg_in;
          dz_pend_d = b_zero;
          dvs_d     = b_mag;
          quo_d     = a_mag;
          rem_d     = '0;
          cnt_d     = CntW'(n);
`ifdef DIV_OVF_FLAG_EN
          ovf_pend_d = ovf_in;
`endif
        end
      end

      StCalc: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CntW'(1);
      end

      StFix: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (dz_pend_q) begin
          q_d  = '1;
          r_d  = '0;
          dz_d = 1'b1;
        end else begin
          // Most-negative / -1 wraps naturally here: the magnitude is
          // 2^(n-1), and its negation is itself.
          q_d  = q_neg_q ? (~quo_q + {{(n-1){1'b0}}, 1'b1}) : quo_q;
          r_d  = a_neg_q ? (~rem_q + {{(m-1){1'b0}}, 1'b1}) : rem_q;
          dz_d = 1'b0;
        end
`ifdef DIV_OVF_FLAG_EN
        ovf_d = ovf_pend_q;
`endif
      end

      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      a_neg_q   <= 1'b0;
      q_neg_q   <= 1'b0;
      dz_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      dz_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      a_neg_q   <= a_neg_d;
      q_neg_q   <= q_neg_d;
      dz_pend_q <= dz_pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      q_q       <= q_d;
      r_q       <= r_d;
      dz_q      <= dz_d;
    end
  end

`ifdef DIV_OVF_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;

endmodule
